// File: rtl/ex_mem_skid_if.sv
// rtl/ex_mem_skid_if.sv - EX->MEM handshake bundle for the ex_mem_skid stage
//
// Purpose : groups the upstream (EX) and downstream (MEM) valid/ready
//           handshakes and their payload fields into one bundle.
// Signals : in_valid/in_ready/in_ctrl/in_rd/in_data    EX side
//           out_valid/out_ready/out_ctrl/out_rd/out_data MEM side
// Modports: slave  - the pipeline stage itself
//           master - the environment driving EX and sinking MEM
interface ex_mem_skid_if #(
    parameter int CTRL_W = 4,
    parameter int RD_W   = 5,
    parameter int DATA_W = 64
);
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [RD_W-1:0]   in_rd;
    logic [DATA_W-1:0] in_data;

    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [RD_W-1:0]   out_rd;
    logic [DATA_W-1:0] out_data;

    modport slave (
        input  in_valid, in_ctrl, in_rd, in_data, out_ready,
        output in_ready, out_valid, out_ctrl, out_rd, out_data
    );

    modport master (
        output in_valid, in_ctrl, in_rd, in_data, out_ready,
        input  in_ready, out_valid, out_ctrl, out_rd, out_data
    );
endinterface

// File: rtl/ex_mem_skid.sv
// rtl/ex_mem_skid.sv - EX/MEM pipeline register built as a 2-entry skid buffer
//
// Purpose : decouples the EX stage from MEM backpressure. A main (head)
//           register always feeds MEM; a skid register catches the one
//           entry EX may launch in the same cycle MEM stalls, so in_ready
//           can be a flop with no combinational path from out_ready.
// Ports   : clk        clock, rising edge
//           rst        asynchronous active-high reset
//           flush      drop all held entries and the current input
//           bus        ex_mem_skid_if.slave handshake/payload bundle
//           occupancy  number of held entries (0..2)
//           stall_cnt  saturating count of cycles with out_valid & !out_ready
module ex_mem_skid #(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 4,
    parameter int CNT_W  = 16,
    parameter int RD_W   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    ex_mem_skid_if.slave     bus,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt
);

    // State encoding equals the number of held entries, so occupancy is
    // the state register itself.
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]        state_q, state_d;
    logic              in_ready_q, in_ready_d;

    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [RD_W-1:0]   main_rd_q, main_rd_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;

    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [RD_W-1:0]   skid_rd_q, skid_rd_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;

    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic              out_valid;
    logic              in_xfer;
    logic              in_take;
    logic              out_xfer;

    assign out_valid = (state_q != ST_EMPTY);
    assign in_xfer   = bus.in_valid & in_ready_q;
    assign out_xfer  = out_valid & bus.out_ready;
    // An input accepted during a flush is handshaken but dropped.
    assign in_take   = in_xfer & ~flush;

    always_comb begin
        state_d     = state_q;
        main_ctrl_d = main_ctrl_q;
        main_rd_d   = main_rd_q;
        main_data_d = main_data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_rd_d   = skid_rd_q;
        skid_data_d = skid_data_q;

        case (state_q)
            ST_EMPTY: begin
                if (in_take) begin
                    main_ctrl_d = bus.in_ctrl;
                    main_rd_d   = bus.in_rd;
                    main_data_d = bus.in_data;
                    state_d     = ST_ONE;
                end
            end
            ST_ONE: begin
                if (in_take && out_xfer) begin
                    // Head leaves and the new entry replaces it directly.
                    main_ctrl_d = bus.in_ctrl;
                    main_rd_d   = bus.in_rd;
                    main_data_d = bus.in_data;
                end else if (in_take) begin
                    // MEM stalled: park the new entry behind the head.
                    skid_ctrl_d = bus.in_ctrl;
                    skid_rd_d   = bus.in_rd;
                    skid_data_d = bus.in_data;
                    state_d     = ST_TWO;
                end else if (out_xfer) begin
                    state_d     = ST_EMPTY;
                end
            end
            ST_TWO: begin
                // in_ready is low here, so no input can arrive.
                if (out_xfer) begin
                    main_ctrl_d = skid_ctrl_q;
                    main_rd_d   = skid_rd_q;
                    main_data_d = skid_data_q;
                    state_d     = ST_ONE;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase

        // Registers keep their stale contents; the state alone hides them.
        if (flush) begin
            state_d = ST_EMPTY;
        end

        in_ready_d = (state_d != ST_TWO);
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid && !bus.out_ready && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            in_ready_q  <= 1'b1;
            main_ctrl_q <= '0;
            main_rd_q   <= '0;
            main_data_q <= '0;
            skid_ctrl_q <= '0;
            skid_rd_q   <= '0;
            skid_data_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            main_ctrl_q <= main_ctrl_d;
            main_rd_q   <= main_rd_d;
            main_data_q <= main_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_rd_q   <= skid_rd_d;
            skid_data_q <= skid_data_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Control and rd are squashed when empty so MEM never sees a stale
    // write-enable; data is left raw.
    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid;
    assign bus.out_ctrl  = out_valid ? main_ctrl_q : '0;
    assign bus.out_rd    = out_valid ? main_rd_q : '0;
    assign bus.out_data  = main_data_q;
    assign occupancy     = state_q;
    assign stall_cnt     = stall_cnt_q;

endmodule

// File: tb/tb_ex_mem_skid.sv
// tb/tb_ex_mem_skid.sv - scoreboard bench for ex_mem_skid
module tb_ex_mem_skid;

    typedef struct packed {
        logic [3:0]  ctrl;
        logic [4:0]  rd;
        logic [63:0] data;
    } ent_t;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [3:0]  in_ctrl;
    logic [4:0]  in_rd;
    logic [63:0] in_data;
    logic        out_ready;

    logic [1:0]  occupancy;
    logic [15:0] stall_cnt;
    logic [1:0]  occupancy_b;
    logic [3:0]  stall_cnt_b;

    int checks = 0;
    int errors = 0;

    ent_t        sb[$];
    logic [15:0] stall_exp = '0;
    logic [3:0]  stall4_exp = '0;

    ex_mem_skid_if #(.CTRL_W(4), .RD_W(5), .DATA_W(64)) bus_a ();
    ex_mem_skid_if #(.CTRL_W(4), .RD_W(5), .DATA_W(64)) bus_b ();

    assign bus_a.in_valid  = in_valid;
    assign bus_a.in_ctrl   = in_ctrl;
    assign bus_a.in_rd     = in_rd;
    assign bus_a.in_data   = in_data;
    assign bus_a.out_ready = out_ready;
    assign bus_b.in_valid  = in_valid;
    assign bus_b.in_ctrl   = in_ctrl;
    assign bus_b.in_rd     = in_rd;
    assign bus_b.in_data   = in_data;
    assign bus_b.out_ready = out_ready;

    ex_mem_skid #(.DATA_W(64), .CTRL_W(4), .CNT_W(16), .RD_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .bus       (bus_a),
        .occupancy (occupancy),
        .stall_cnt (stall_cnt)
    );

    ex_mem_skid #(.DATA_W(64), .CTRL_W(4), .CNT_W(4), .RD_W(5)) dut_sat (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .bus       (bus_b),
        .occupancy (occupancy_b),
        .stall_cnt (stall_cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Any reset discards the model state together with the DUT state.
    always @(posedge rst) begin
        sb.delete();
        stall_exp  = '0;
        stall4_exp = '0;
    end

    // Scoreboard monitor: inputs are stable at the falling edge, so the
    // model predicts the outputs of the current cycle and then applies the
    // transfers that the coming rising edge will perform.
    int   m_sz;
    logic m_in_x;
    logic m_out_x;
    always @(negedge clk) begin
        if (!rst) begin
            m_sz = sb.size();
            checks++;
            if (occupancy !== 2'(m_sz)) begin
                errors++;
                $display("FAIL sb_occupancy: got %0d expected %0d", occupancy, m_sz);
            end
            checks++;
            if (bus_a.out_valid !== (m_sz != 0)) begin
                errors++;
                $display("FAIL sb_out_valid: got %0b expected %0b", bus_a.out_valid, m_sz != 0);
            end
            checks++;
            if (bus_a.in_ready !== (m_sz != 2)) begin
                errors++;
                $display("FAIL sb_in_ready: got %0b expected %0b", bus_a.in_ready, m_sz != 2);
            end
            checks++;
            if (occupancy_b !== 2'(m_sz) || bus_b.out_valid !== (m_sz != 0)) begin
                errors++;
                $display("FAIL sb_sat_state: got occ %0d valid %0b expected occ %0d", occupancy_b, bus_b.out_valid, m_sz);
            end
            if (m_sz == 0) begin
                checks++;
                if (bus_a.out_ctrl !== 4'd0 || bus_a.out_rd !== 5'd0) begin
                    errors++;
                    $display("FAIL sb_idle_zero: got ctrl %0h rd %0h expected 0 0", bus_a.out_ctrl, bus_a.out_rd);
                end
            end else begin
                checks++;
                if (bus_a.out_ctrl !== sb[0].ctrl || bus_a.out_rd !== sb[0].rd || bus_a.out_data !== sb[0].data) begin
                    errors++;
                    $display("FAIL sb_head: got %0h/%0h/%0h expected %0h/%0h/%0h", bus_a.out_ctrl, bus_a.out_rd,
                             bus_a.out_data, sb[0].ctrl, sb[0].rd, sb[0].data);
                end
                checks++;
                if (bus_b.out_data !== sb[0].data) begin
                    errors++;
                    $display("FAIL sb_sat_head: got %0h expected %0h", bus_b.out_data, sb[0].data);
                end
            end
            checks++;
            if (stall_cnt !== stall_exp || stall_cnt_b !== stall4_exp) begin
                errors++;
                $display("FAIL sb_stall_cnt: got %0d/%0d expected %0d/%0d", stall_cnt, stall_cnt_b, stall_exp, stall4_exp);
            end

            m_in_x  = in_valid && (m_sz != 2);
            m_out_x = (m_sz != 0) && out_ready;
            if (m_sz != 0 && !out_ready) begin
                if (stall_exp != 16'hFFFF) stall_exp = stall_exp + 16'd1;
                if (stall4_exp != 4'hF) stall4_exp = stall4_exp + 4'd1;
            end
            if (m_out_x) void'(sb.pop_front());
            if (flush) sb.delete();
            else if (m_in_x) sb.push_back('{ctrl: in_ctrl, rd: in_rd, data: in_data});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid  = 1'b0;
        flush     = 1'b0;
        in_ctrl   = '0;
        in_rd     = '0;
        in_data   = '0;
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        checks++;
        if (occupancy !== 2'd0 || bus_a.out_valid !== 1'b0 || bus_a.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: got occ %0d valid %0b ready %0b expected 0 0 1", occupancy, bus_a.out_valid, bus_a.in_ready);
        end
        checks++;
        if (bus_a.out_ctrl !== 4'd0 || bus_a.out_rd !== 5'd0 || bus_a.out_data !== 64'd0 || stall_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_values: got %0h/%0h/%0h/%0d expected all 0", bus_a.out_ctrl, bus_a.out_rd, bus_a.out_data, stall_cnt);
        end
        rst = 1'b0;
        in_valid = 1'b1;
        in_ctrl  = 4'h3;
        in_rd    = 5'd9;
        in_data  = 64'hAA;
        tick();
        in_valid = 1'b0;
        checks++;
        if (bus_a.out_valid !== 1'b1 || bus_a.out_data !== 64'hAA) begin
            errors++;
            $display("FAIL reset_first_xfer: got valid %0b data %0h expected 1 aa", bus_a.out_valid, bus_a.out_data);
        end
        tick();
    endtask

    task automatic test_streaming();
        out_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            in_valid = 1'b1;
            in_ctrl  = 4'(k);
            in_rd    = 5'(k);
            in_data  = 64'(k);
            tick();
            checks++;
            if (bus_a.out_valid !== 1'b1 || bus_a.out_data !== 64'(k) || occupancy !== 2'd1) begin
                errors++;
                $display("FAIL stream_%0d: got valid %0b data %0h occ %0d expected 1 %0h 1", k, bus_a.out_valid,
                         bus_a.out_data, occupancy, k);
            end
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_ctrl   = 4'h5;
        in_rd     = 5'd1;
        in_data   = 64'hA;
        tick();
        in_ctrl   = 4'h6;
        in_rd     = 5'd2;
        in_data   = 64'hB;
        tick();
        in_valid  = 1'b0;
        checks++;
        if (occupancy !== 2'd2 || bus_a.in_ready !== 1'b0 || bus_a.out_data !== 64'hA) begin
            errors++;
            $display("FAIL bp_full: got occ %0d ready %0b data %0h expected 2 0 a", occupancy, bus_a.in_ready, bus_a.out_data);
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (occupancy !== 2'd1 || bus_a.in_ready !== 1'b1 || bus_a.out_data !== 64'hB || bus_a.out_rd !== 5'd2) begin
            errors++;
            $display("FAIL bp_drain: got occ %0d ready %0b data %0h expected 1 1 b", occupancy, bus_a.in_ready, bus_a.out_data);
        end
        tick();
        checks++;
        if (occupancy !== 2'd0 || bus_a.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_empty: got occ %0d valid %0b expected 0 0", occupancy, bus_a.out_valid);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_ctrl   = 4'h1;
        in_data   = 64'h11;
        tick();
        in_data   = 64'h22;
        tick();
        in_data   = 64'hC;
        in_ctrl   = 4'hC;
        flush     = 1'b1;
        tick();
        flush     = 1'b0;
        in_valid  = 1'b0;
        checks++;
        if (bus_a.out_valid !== 1'b0 || occupancy !== 2'd0 || bus_a.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_state: got valid %0b occ %0d ready %0b expected 0 0 1", bus_a.out_valid, occupancy, bus_a.in_ready);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (bus_a.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL flush_no_c: got valid %0b data %0h expected 0", bus_a.out_valid, bus_a.out_data);
            end
        end
    endtask

    task automatic test_saturation();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 64'h5A5A;
        tick();
        in_valid  = 1'b0;
        repeat (20) tick();
        checks++;
        if (stall_cnt_b !== 4'd15) begin
            errors++;
            $display("FAIL sat_reach: got %0d expected 15", stall_cnt_b);
        end
        repeat (5) tick();
        checks++;
        if (stall_cnt_b !== 4'd15) begin
            errors++;
            $display("FAIL sat_hold: got %0d expected 15", stall_cnt_b);
        end
        out_ready = 1'b1;
        tick();
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_ctrl   = 4'hF;
        in_rd     = 5'h1F;
        in_data   = 64'hE;
        tick();
        in_valid  = 1'b0;
        checks++;
        if (bus_a.out_valid !== 1'b1 || bus_a.out_ctrl !== 4'hF) begin
            errors++;
            $display("FAIL arst_pre: got valid %0b ctrl %0h expected 1 f", bus_a.out_valid, bus_a.out_ctrl);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (bus_a.out_valid !== 1'b0 || bus_a.out_ctrl !== 4'h0 || bus_a.out_rd !== 5'h0 || occupancy !== 2'd0) begin
            errors++;
            $display("FAIL arst_immediate: got valid %0b ctrl %0h rd %0h occ %0d expected 0 0 0 0", bus_a.out_valid,
                     bus_a.out_ctrl, bus_a.out_rd, occupancy);
        end
        rst       = 1'b0;
        in_valid  = 1'b1;
        in_ctrl   = 4'h2;
        in_rd     = 5'd3;
        in_data   = 64'hF00D;
        out_ready = 1'b1;
        tick();
        in_valid  = 1'b0;
        checks++;
        if (bus_a.out_valid !== 1'b1 || bus_a.out_data !== 64'hF00D) begin
            errors++;
            $display("FAIL arst_after: got valid %0b data %0h expected 1 f00d", bus_a.out_valid, bus_a.out_data);
        end
        tick();
        checks++;
        if (bus_a.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL arst_no_stale: got valid %0b data %0h expected 0", bus_a.out_valid, bus_a.out_data);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 10000; k++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 63) == 0);
            in_ctrl   = 4'($urandom);
            in_rd     = 5'($urandom);
            in_data   = {$urandom, $urandom};
            tick();
        end
        idle_inputs();
        repeat (4) tick();
        checks++;
        if (occupancy !== 2'd0) begin
            errors++;
            $display("FAIL rand_drained: got occ %0d expected 0", occupancy);
        end
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_saturation();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
